// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - registered RV32/RV64 immediate decode stage with 2-entry skid buffer
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   flush_i                        drop every held entry, block accept this cycle
//   in_valid_i, in_ready_o         upstream handshake
//   in_instr_i, in_pc_i            instruction word and its address
//   out_valid_o, out_ready_i       downstream handshake
//   out_imm_o, out_fmt_o           extended immediate and format code
//   out_pc_o, out_target_o         entry PC and pc + imm
//   out_illegal_o                  unrecognised encoding
module imm_decode_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_instr_i,
  input  logic [XLEN-1:0] in_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_imm_o,
  output logic [2:0]      out_fmt_o,
  output logic [XLEN-1:0] out_pc_o,
  output logic [XLEN-1:0] out_target_o,
  output logic            out_illegal_o
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic            illegal;
  } entry_t;

  entry_t          dec;
  entry_t          main_q, main_d;
  entry_t          skid_q, skid_d;
  logic            main_valid_q, main_valid_d;
  logic            skid_valid_q, skid_valid_d;
  logic            accept;
  logic            consume;
  logic [2:0]      fmt;
  logic            illegal;
  logic [XLEN-1:0] imm;

  // Format classification from the opcode.
  always_comb begin
    fmt     = FMT_NONE;
    illegal = 1'b0;
    if (in_instr_i[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (in_instr_i[6:0])
        7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111: fmt = FMT_I;
        7'b1110011: fmt = in_instr_i[14] ? FMT_Z : FMT_I;
        7'b0100011: fmt = FMT_S;
        7'b1100011: fmt = FMT_B;
        7'b0110111, 7'b0010111: fmt = FMT_U;
        7'b1101111: fmt = FMT_J;
        7'b0110011: fmt = FMT_NONE;
        // OP-IMM-32 / OP-32 only exist on RV64
        7'b0011011: begin
          if (XLEN == 64) fmt = FMT_I;
          else            illegal = 1'b1;
        end
        7'b0111011: begin
          if (XLEN != 64) illegal = 1'b1;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

  // Size casts of signed operands sign-extend to XLEN.
  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I: imm = XLEN'($signed(in_instr_i[31:20]));
      FMT_S: imm = XLEN'($signed({in_instr_i[31:25], in_instr_i[11:7]}));
      FMT_B: imm = XLEN'($signed({in_instr_i[31], in_instr_i[7], in_instr_i[30:25],
                                  in_instr_i[11:8], 1'b0}));
      FMT_U: imm = XLEN'($signed({in_instr_i[31:12], 12'b0}));
      FMT_J: imm = XLEN'($signed({in_instr_i[31], in_instr_i[19:12], in_instr_i[20],
                                  in_instr_i[30:21], 1'b0}));
      FMT_Z: imm = XLEN'(in_instr_i[19:15]);
      default: imm = '0;
    endcase
  end

  always_comb begin
    dec.imm     = imm;
    dec.fmt     = fmt;
    dec.pc      = in_pc_i;
    dec.target  = in_pc_i + imm;
    dec.illegal = illegal;
  end

  // in_ready depends only on registered state, never on out_ready.
  assign in_ready_o = !skid_valid_q;
  assign accept     = in_valid_i && in_ready_o && !flush_i;
  assign consume    = main_valid_q && out_ready_i;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_d       = '0;
      skid_d       = '0;
    end else begin
      if (consume) begin
        if (skid_valid_q) begin
          main_d       = skid_q;
          skid_valid_d = 1'b0;
        end else begin
          main_valid_d = 1'b0;
        end
      end
      // An accept implies the skid is empty, so a consuming main is free.
      if (accept) begin
        if (!main_valid_q || consume) begin
          main_d       = dec;
          main_valid_d = 1'b1;
        end else begin
          skid_d       = dec;
          skid_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign out_valid_o   = main_valid_q;
  assign out_imm_o     = main_q.imm;
  assign out_fmt_o     = main_q.fmt;
  assign out_pc_o      = main_q.pc;
  assign out_target_o  = main_q.target;
  assign out_illegal_o = main_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - self-checking bench for imm_decode_stage (XLEN 64 and 32 side by side)
module tb_imm_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic [31:0] in_pc32;
  assign in_pc32 = in_pc[31:0];

  logic        in_ready, out_valid, out_illegal;
  logic [63:0] out_imm, out_pc, out_target;
  logic [2:0]  out_fmt;
  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32, out_pc32, out_target32;
  logic [2:0]  out_fmt32;

  imm_decode_stage #(.XLEN(64)) u64 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_instr_i(in_instr), .in_pc_i(in_pc),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_imm_o(out_imm), .out_fmt_o(out_fmt),
    .out_pc_o(out_pc), .out_target_o(out_target), .out_illegal_o(out_illegal)
  );

  imm_decode_stage #(.XLEN(32)) u32 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready32), .in_instr_i(in_instr), .in_pc_i(in_pc32),
    .out_valid_o(out_valid32), .out_ready_i(out_ready), .out_imm_o(out_imm32), .out_fmt_o(out_fmt32),
    .out_pc_o(out_pc32), .out_target_o(out_target32), .out_illegal_o(out_illegal32)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference decoder built from the field layouts with plain arithmetic.
  function automatic void model(input logic [31:0] ins, input logic [63:0] pc, input int xlen,
                                output logic [2:0] f, output logic il,
                                output logic [63:0] im, output logic [63:0] tg);
    logic [63:0] v;
    v  = 64'd0;
    f  = 3'd0;
    il = 1'b0;
    if (ins[1:0] != 2'b11) il = 1'b1;
    else begin
      case (ins[6:0])
        7'h13, 7'h03, 7'h67, 7'h0F: f = 3'd1;
        7'h73: f = ins[14] ? 3'd6 : 3'd1;
        7'h23: f = 3'd2;
        7'h63: f = 3'd3;
        7'h37, 7'h17: f = 3'd4;
        7'h6F: f = 3'd5;
        7'h33: f = 3'd0;
        7'h1B: if (xlen == 64) f = 3'd1; else il = 1'b1;
        7'h3B: if (xlen != 64) il = 1'b1;
        default: il = 1'b1;
      endcase
    end
    case (f)
      3'd1: begin
        v = 64'(ins[31:20]);
        if (ins[31]) v = v - 64'd4096;
      end
      3'd2: begin
        v = 64'({ins[31:25], ins[11:7]});
        if (ins[31]) v = v - 64'd4096;
      end
      3'd3: begin
        v = (64'(ins[7]) << 11) + (64'(ins[30:25]) << 5) + (64'(ins[11:8]) << 1);
        if (ins[31]) v = v - 64'd4096;
      end
      3'd4: begin
        v = 64'(ins[30:12]) << 12;
        if (ins[31]) v = v - 64'h8000_0000;
      end
      3'd5: begin
        v = (64'(ins[19:12]) << 12) + (64'(ins[20]) << 11) + (64'(ins[30:21]) << 1);
        if (ins[31]) v = v - 64'h10_0000;
      end
      3'd6: v = 64'(ins[19:15]);
      default: v = 64'd0;
    endcase
    if (xlen == 32) begin
      im = {32'h0, v[31:0]};
      tg = {32'h0, pc[31:0] + v[31:0]};
    end else begin
      im = v;
      tg = pc + v;
    end
  endfunction

  task automatic cmp_model(input logic [31:0] ins, input logic [63:0] pc);
    logic [2:0]  f;
    logic        il;
    logic [63:0] im, tg;
    model(ins, pc, 64, f, il, im, tg);
    chk("rnd_fmt64", 64'(out_fmt), 64'(f));
    chk("rnd_ill64", 64'(out_illegal), 64'(il));
    chk("rnd_imm64", out_imm, im);
    chk("rnd_tgt64", out_target, tg);
    chk("rnd_pc64", out_pc, pc);
    model(ins, pc, 32, f, il, im, tg);
    chk("rnd_fmt32", 64'(out_fmt32), 64'(f));
    chk("rnd_ill32", 64'(out_illegal32), 64'(il));
    chk("rnd_imm32", 64'(out_imm32), im);
    chk("rnd_tgt32", 64'(out_target32), tg);
    chk("rnd_pc32", 64'(out_pc32), {32'h0, pc[31:0]});
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [2:0]  fmt64;
    logic        ill64;
    logic [63:0] imm64;
    logic [63:0] tgt64;
    logic [2:0]  fmt32;
    logic        ill32;
    logic [31:0] imm32;
    logic [31:0] tgt32;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } ent_t;

  vec_t vecs[13];
  ent_t q[$];
  logic [6:0] ops[13] = '{7'h13, 7'h03, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63,
                          7'h37, 7'h17, 7'h6F, 7'h33, 7'h1B, 7'h3B};

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 12)];
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{32'hFFF00093, 64'h1000, 3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFF,
                 3'd1, 1'b0, 32'hFFFF_FFFF, 32'hFFF};
    vecs[1]  = '{32'h800000B7, 64'h0, 3'd4, 1'b0, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000,
                 3'd4, 1'b0, 32'h8000_0000, 32'h8000_0000};
    vecs[2]  = '{32'hFFDFF06F, 64'h2000, 3'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1FFC,
                 3'd5, 1'b0, 32'hFFFF_FFFC, 32'h1FFC};
    vecs[3]  = '{32'h00000463, 64'h2000, 3'd3, 1'b0, 64'h8, 64'h2008, 3'd3, 1'b0, 32'h8, 32'h2008};
    vecs[4]  = '{32'h0000007F, 64'h3000, 3'd0, 1'b1, 64'h0, 64'h3000, 3'd0, 1'b1, 32'h0, 32'h3000};
    vecs[5]  = '{32'h0000001B, 64'h10, 3'd1, 1'b0, 64'h0, 64'h10, 3'd0, 1'b1, 32'h0, 32'h10};
    vecs[6]  = '{32'h0000D073, 64'h400, 3'd6, 1'b0, 64'h1, 64'h401, 3'd6, 1'b0, 32'h1, 32'h401};
    vecs[7]  = '{32'h00000033, 64'h500, 3'd0, 1'b0, 64'h0, 64'h500, 3'd0, 1'b0, 32'h0, 32'h500};
    vecs[8]  = '{32'h0000003B, 64'h500, 3'd0, 1'b0, 64'h0, 64'h500, 3'd0, 1'b1, 32'h0, 32'h500};
    vecs[9]  = '{32'h00000002, 64'h600, 3'd0, 1'b1, 64'h0, 64'h600, 3'd0, 1'b1, 32'h0, 32'h600};
    vecs[10] = '{32'hFE112C23, 64'h100, 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'hF8,
                 3'd2, 1'b0, 32'hFFFF_FFF8, 32'hF8};
    vecs[11] = '{32'h00000073, 64'h700, 3'd1, 1'b0, 64'h0, 64'h700, 3'd1, 1'b0, 32'h0, 32'h700};
    vecs[12] = '{32'h00100013, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0, 64'h1, 64'h0,
                 3'd1, 1'b0, 32'h1, 32'h0};

    // Reset state
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'h0; in_pc = 64'h0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_imm", out_imm, 64'd0);
    chk("rst_fmt", 64'(out_fmt), 64'd0);
    chk("rst_pc", out_pc, 64'd0);
    chk("rst_target", out_target, 64'd0);
    chk("rst_illegal", 64'(out_illegal), 64'd0);
    chk("rst_out_valid32", 64'(out_valid32), 64'd0);
    rst_n = 1'b1;
    cycle();

    // Directed vectors, streamed back to back with out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_pc    = vecs[i].pc;
      cycle();
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_fmt64", i), 64'(out_fmt), 64'(vecs[i].fmt64));
      chk($sformatf("vec%0d_ill64", i), 64'(out_illegal), 64'(vecs[i].ill64));
      chk($sformatf("vec%0d_imm64", i), out_imm, vecs[i].imm64);
      chk($sformatf("vec%0d_tgt64", i), out_target, vecs[i].tgt64);
      chk($sformatf("vec%0d_pc64", i), out_pc, vecs[i].pc);
      chk($sformatf("vec%0d_fmt32", i), 64'(out_fmt32), 64'(vecs[i].fmt32));
      chk($sformatf("vec%0d_ill32", i), 64'(out_illegal32), 64'(vecs[i].ill32));
      chk($sformatf("vec%0d_imm32", i), 64'(out_imm32), 64'(vecs[i].imm32));
      chk($sformatf("vec%0d_tgt32", i), 64'(out_target32), 64'(vecs[i].tgt32));
    end
    in_valid = 1'b0;
    cycle();
    chk("vec_drain_valid", 64'(out_valid), 64'd0);

    // Backpressure: 8 entries offered, downstream stalled for 3 cycles
    begin
      int acc_n, del_n, cyc;
      acc_n = 0; del_n = 0; cyc = 0;
      in_instr = 32'h00000013;
      while (del_n < 8 && cyc < 60) begin
        out_ready = (cyc >= 3);
        in_valid  = (acc_n < 8);
        in_pc     = 64'h5000 + 64'(acc_n) * 64'd4;
        if (cyc == 1) chk("bp_ready_c1", 64'(in_ready), 64'd1);
        if (cyc == 2) begin
          chk("bp_ready_c2", 64'(in_ready), 64'd0);
          chk("bp_accepted", 64'(acc_n), 64'd2);
        end
        if (cyc == 3) chk("bp_ready_c3", 64'(in_ready), 64'd0);
        if (cyc == 4) chk("bp_ready_c4", 64'(in_ready), 64'd1);
        if (out_valid && out_ready) begin
          chk("bp_order", out_pc, 64'h5000 + 64'(del_n) * 64'd4);
          del_n++;
        end
        if (in_valid && in_ready) acc_n++;
        cycle();
        cyc++;
      end
      in_valid = 1'b0;
      chk("bp_delivered", 64'(del_n), 64'd8);
      chk("bp_accepted_total", 64'(acc_n), 64'd8);
      chk("bp_empty_after", 64'(out_valid), 64'd0);
    end

    // Flush with both entries held and a same-cycle offer and consume
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00000013;
    in_pc = 64'h6000; cycle();
    in_pc = 64'h6004; cycle();
    chk("fl_full_ready", 64'(in_ready), 64'd0);
    chk("fl_full_valid", 64'(out_valid), 64'd1);
    flush = 1'b1; out_ready = 1'b1; in_pc = 64'h6008;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    chk("fl_out_valid32", 64'(out_valid32), 64'd0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("fl_no_ghost", 64'(out_valid), 64'd0);
    end
    in_valid = 1'b1; in_pc = 64'h6100;
    cycle();
    in_valid = 1'b0;
    chk("fl_recover_valid", 64'(out_valid), 64'd1);
    chk("fl_recover_pc", out_pc, 64'h6100);
    cycle();

    // Asynchronous reset while entries are held
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF00093;
    in_pc = 64'h7000; cycle();
    in_pc = 64'h7004; cycle();
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_imm", out_imm, 64'd0);
    chk("arst_fmt", 64'(out_fmt), 64'd0);
    chk("arst_pc", out_pc, 64'd0);
    chk("arst_target", out_target, 64'd0);
    chk("arst_illegal", 64'(out_illegal), 64'd0);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    cycle();
    chk("arst_stays_empty", 64'(out_valid), 64'd0);

    // Randomized traffic against the queue-based reference
    q.delete();
    for (int c = 0; c < 600; c++) begin
      logic acc;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      in_instr  = gen_instr();
      in_pc     = {$urandom, $urandom};
      chk("rnd_in_ready", 64'(in_ready), 64'(q.size() < 2));
      chk("rnd_out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("rnd_in_ready32", 64'(in_ready32), 64'(q.size() < 2));
      acc = in_valid && in_ready && !flush;
      if (flush) begin
        q.delete();
      end else begin
        if (out_valid && out_ready && q.size() > 0) begin
          cmp_model(q[0].instr, q[0].pc);
          void'(q.pop_front());
        end
        if (acc) q.push_back('{in_instr, in_pc});
      end
      cycle();
    end
    flush = 1'b0; in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered immediate-decode pipeline stage for the RV32/RV64 decode path. Accepts one 32-bit instruction plus its PC per handshake and classifies the encoding format. Emits the sign- or zero-extended immediate, the PC-relative target (pc + imm), and an illegal-opcode flag. Decoupled on both sides by valid/ready, with a 2-entry skid buffer so full throughput is kept under backpressure.

## Interface
- XLEN, 64, datapath width; legal values 32 and 64
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous; discards every held entry
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction address
- out_valid  out  1  decoded entry available
- out_ready  in  1  downstream accepts
- out_imm  out  XLEN  extended immediate
- out_fmt  out  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z
- out_pc  out  XLEN  PC of the entry
- out_target  out  XLEN  out_pc + out_imm, modulo 2^XLEN
- out_illegal  out  1  unrecognised encoding

## Operation
- Format by opcode in_instr[6:0]:
  - I: 0010011, 0000011, 1100111, 0001111
  - I: 1110011 with funct3[2]=0
  - Z: 1110011 with funct3[2]=1
  - S: 0100011
  - B: 1100011
  - U: 0110111, 0010111
  - J: 1101111
  - NONE, legal: 0110011
- RV64 only: 0011011 is I and 0111011 is NONE. With XLEN=32 both are illegal.
- Any other opcode, or in_instr[1:0] != 2'b11: illegal=1, fmt NONE, imm 0.
- Immediates; sext means sign-extend from instr[31] to XLEN:
  - I: sext(instr[31:20])
  - S: sext({instr[31:25], instr[11:7]})
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})
  - U: sext({instr[31:12], 12'b0}). With XLEN=64, bits 63:32 copy instr[31].
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})
  - Z: zero-extended instr[19:15]
  - NONE: 0
- Decode and target add are combinational from the input. Results are captured into the main register on accept, so the adder does not sit on the output path.
- Skid buffer:
  - Main register feeds the outputs.
  - Skid register holds one extra entry.
  - in_ready = !skid_valid (registered state only, no combinational path from out_ready).
- Accept when in_valid && in_ready:
  - Main empty, or main being consumed this cycle: entry goes to main.
  - Otherwise: entry goes to skid.
- Consume when out_valid && out_ready: main takes skid contents if skid_valid, else main goes empty.
- Simultaneous accept and consume with skid full cannot occur, because in_ready=0.
- Order is strictly FIFO.
- flush:
  - Clears main_valid and skid_valid.
  - Blocks any accept that cycle, whatever in_valid is.
  - Overrides a same-cycle consume; the downstream handshake that cycle is void.
- Reset (rst_n low, asynchronous):
  - out_valid=0, in_ready=1.
  - out_imm, out_fmt, out_pc, out_target, out_illegal all 0.
  - Skid contents are 0.
  - Reset mid-transfer drops all entries.

## Timing
- Latency: accept in cycle N gives out_valid in cycle N+1 with that entry's data.
- Throughput: one entry per cycle while out_ready=1.
- Downstream stall:
  - The first extra accepted entry lands in skid.
  - in_ready drops in the following cycle.
  - in_ready returns to 1 the cycle after skid drains into main.
- Outputs are stable while out_valid && !out_ready. Only a consume changes them.
- out_* data is don't-care while out_valid=0. Implementation holds the last value, except after reset or flush.

## Test plan
- XLEN=64: 0xFFF00093 (addi x1,x0,-1), pc 0x1000 -> next cycle out_fmt=1, out_imm=0xFFFF_FFFF_FFFF_FFFF, out_target=0xFFF, out_illegal=0.
- XLEN=64: 0x800000B7 (lui) -> fmt=4, imm=0xFFFF_FFFF_8000_0000. XLEN=32 same instr -> imm=0x8000_0000.
- 0xFFDFF06F (jal x0,-4), pc 0x2000 -> fmt=5, imm=-4, target=0x1FFC. 0x00000463 (beq +8), pc 0x2000 -> fmt=3, imm=8, target=0x2008.
- 0x0000007F -> illegal=1, fmt=0, imm=0. 0x0000001B -> legal I on XLEN=64, illegal on XLEN=32. 0x0000D073 (csrrwi, zimm=1) -> fmt=6, imm=1.
- Backpressure:
  - Stream 8 back-to-back entries with out_ready held 0 for 3 cycles.
  - Expected: exactly 2 entries accepted, in_ready=0 from the cycle after the second accept.
  - On release, all 8 are delivered in order with no loss or duplication.
- Flush with both entries held, asserted together with in_valid=1 and out_ready=1:
  - Next cycle out_valid=0 and in_ready=1.
  - The entry offered in the flush cycle never appears.
- Reset asserted mid-stream: out_valid drops with no clock edge, and all outputs read 0.
